// File: rtl/pair_addr_sequencer.sv
// pair_addr_sequencer
// Walks a half-open range of pair indices [base, limit) and offers each pair
// as an even/odd address pair to a downstream memory with a valid/ready
// handshake. A run ends with a one-cycle done pulse, or earlier on abort.
// A start with an empty or inverted range is refused with a one-cycle err.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous reset, active low
//   start   - request a run (sampled only while idle)
//   abort   - cancel the current run
//   base    - first pair index (inclusive)
//   limit   - end pair index (exclusive)
//   ready   - downstream accepts the offered pair
//   addr_a  - even address {idx,0}
//   addr_b  - odd address  {idx,1}
//   valid   - a pair is offered
//   busy    - run in progress or finishing
//   done    - one-cycle pulse after the last accepted pair
//   err     - one-cycle pulse for a refused start
//   count   - pairs accepted in the current or last run
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | waiting for start; addresses show the last idx
// S_RUN  | offering pair idx, valid=1
// S_DONE | one cycle after the last handshake, done=1
module pair_addr_sequencer #(
  parameter int PAIR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PAIR_W-1:0] base,
  input  logic [PAIR_W-1:0] limit,
  input  logic              ready,
  output logic [PAIR_W:0]   addr_a,
  output logic [PAIR_W:0]   addr_b,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PAIR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PAIR_W-1:0] IDX_ONE = PAIR_W'(1);
  localparam logic [PAIR_W:0]   CNT_ONE = (PAIR_W + 1)'(1);

  state_t            state;
  logic [PAIR_W-1:0] idx;
  logic [PAIR_W-1:0] limit_q;
  logic [PAIR_W-1:0] last_idx;
  logic              at_last;

  // limit_q >= 1 whenever a run is active, so this never underflows in RUN.
  assign last_idx = limit_q - IDX_ONE;
  assign at_last  = (idx == last_idx);

  assign addr_a = {idx, 1'b0};
  assign addr_b = {idx, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      limit_q <= '0;
      count   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (base < limit) begin
              limit_q <= limit;
              idx     <= base;
              count   <= '0;
              state   <= S_RUN;
              valid   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // A handshake always counts, even when abort lands in the same cycle.
          if (ready) begin
            count <= count + CNT_ONE;
            if (!at_last)
              idx <= idx + IDX_ONE;
          end
          if (abort) begin
            state <= S_IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (ready && at_last) begin
            state <= S_DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_addr_sequencer.sv
// Self-checking bench for pair_addr_sequencer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pair_addr_sequencer;

  localparam int PAIR_W = 13;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [PAIR_W-1:0] base;
  logic [PAIR_W-1:0] limit;
  logic              ready;
  logic [PAIR_W:0]   addr_a;
  logic [PAIR_W:0]   addr_b;
  logic              valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [PAIR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a run is the queue of pair indices still to be accepted.
  bit m_run;
  bit m_done;
  bit m_err;
  int m_q[$];
  int m_cnt;

  pair_addr_sequencer #(.PAIR_W(PAIR_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .base   (base),
    .limit  (limit),
    .ready  (ready),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .valid  (valid),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_q.delete();
  endtask

  task automatic check_outputs();
    chk("valid", 32'(valid), 32'(m_run));
    chk("busy",  32'(busy),  32'(m_run || m_done));
    chk("done",  32'(done),  32'(m_done));
    chk("err",   32'(err),   32'(m_err));
    chk("count", 32'(count), 32'(m_cnt));
    if (m_run) begin
      chk("addr_a", 32'(addr_a), 32'(m_q[0] * 2));
      chk("addr_b", 32'(addr_b), 32'(m_q[0] * 2 + 1));
    end
  endtask

  // One clock: drive inputs for this cycle, advance the model, check outputs.
  task automatic step(input bit s, input bit a, input int b, input int l, input bit r);
    bit was_done;
    int tmp;
    @(negedge clk);
    start = s;
    abort = a;
    base  = PAIR_W'(b);
    limit = PAIR_W'(l);
    ready = r;
    was_done = m_done;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_run) begin
      if (r) begin
        m_cnt++;
        tmp = m_q.pop_front();
      end
      if (a) m_run = 1'b0;
      else if (r && m_q.size() == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end else if (!was_done && s) begin
      if (b < l) begin
        m_q.delete();
        for (int i = b; i < l; i++) m_q.push_back(i);
        m_cnt = 0;
        m_run = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int done_pulses;
    int b, l, sel;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base  = '0;
    limit = '0;
    ready = 1'b0;
    model_reset();

    #12;
    chk("rst_addr_b", 32'(addr_b), 32'd1);
    check_outputs();

    // Release reset and present start on the very first edge.
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 3, 5, 1);
    chk("first_edge_start", 32'(valid), 32'd1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Full run 1024..1536 with ready held high.
    step(1, 0, 1024, 1536, 1);
    chk("full_first_a", 32'(addr_a), 32'd2048);
    chk("full_first_b", 32'(addr_b), 32'd2049);
    for (int i = 0; i < 511; i++) step(0, 0, 1024, 1536, 1);
    chk("full_last_a", 32'(addr_a), 32'd3070);
    chk("full_last_b", 32'(addr_b), 32'd3071);
    step(0, 0, 1024, 1536, 1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_count", 32'(count), 32'd512);
    step(0, 0, 1024, 1536, 1);
    chk("full_idle_busy", 32'(busy), 32'd0);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    done_pulses = 0;
    step(1, 0, 0, 4, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 4, (i % 4 == 0) || (i % 4 == 3));
      if (done) done_pulses++;
    end
    chk("bp_done_pulses", 32'(done_pulses), 32'd1);
    chk("bp_count", 32'(count), 32'd4);

    // Rejected starts.
    step(1, 0, 1536, 1536, 0);
    chk("rej_err_eq", 32'(err), 32'd1);
    step(0, 0, 1536, 1536, 0);
    step(1, 0, 1600, 1024, 0);
    chk("rej_err_inv", 32'(err), 32'd1);
    chk("rej_busy", 32'(busy), 32'd0);
    step(0, 0, 0, 0, 0);

    // Abort together with the 11th handshake.
    step(1, 0, 1024, 1536, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1024, 1536, 1);
    step(0, 1, 1024, 1536, 1);
    chk("abort_count", 32'(count), 32'd11);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset mid-run at idx 1100.
    step(1, 0, 1024, 1536, 1);
    for (int i = 0; i < 76; i++) step(0, 0, 1024, 1536, 1);
    chk("pre_rst_addr", 32'(addr_a), 32'd2200);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midrst_addr_a", 32'(addr_a), 32'd0);
    chk("midrst_addr_b", 32'(addr_b), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1024, 1536, 1);
    chk("post_rst_no_run", 32'(valid), 32'd0);
    step(1, 0, 1024, 1030, 1);
    chk("restart_a", 32'(addr_a), 32'd2048);
    chk("restart_b", 32'(addr_b), 32'd2049);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

    // Start in RUN with a different range is ignored.
    step(1, 0, 100, 110, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 2, (i % 3) != 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("ignore_count", 32'(count), 32'd10);

    // Randomized traffic, including ranges touching the top of the index space.
    for (int n = 0; n < 4000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        b = int'($urandom_range(8180, 8190));
        l = int'($urandom_range(8183, 8191));
      end else begin
        b = int'($urandom_range(0, 30));
        l = int'($urandom_range(0, 40));
      end
      step($urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0, b, l,
           $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pair_addr_sequencer.md
PAIR_ADDR_SEQUENCER -- requirements
Module: pair_addr_sequencer

Interface
REQ-001 The block SHALL have parameter PAIR_W, default 13, giving the pair-index width; the address width is PAIR_W+1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a run; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current run.
REQ-006 The block SHALL have port base, input, PAIR_W bits: first pair index, inclusive.
REQ-007 The block SHALL have port limit, input, PAIR_W bits: end pair index, exclusive.
REQ-008 The block SHALL have port ready, input, 1 bit: the downstream memory accepts the current pair.
REQ-009 The block SHALL have port addr_a, output, PAIR_W+1 bits: even address of the current pair, {idx,1'b0}.
REQ-010 The block SHALL have port addr_b, output, PAIR_W+1 bits: odd address of the current pair, {idx,1'b1}.
REQ-011 The block SHALL have port valid, output, 1 bit: the current addr_a/addr_b pair is offered.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN or DONE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last accepted pair.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-015 The block SHALL have port count, output, PAIR_W+1 bits: pairs accepted in the current or last run.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 IDLE: when start=1 and base<limit, the block SHALL latch base and limit, set idx=base, clear count to 0 and enter RUN on the next edge.
REQ-018 IDLE: when start=1 and base>=limit, the block SHALL assert err for exactly one cycle (the cycle after start) and remain in IDLE.
REQ-019 valid SHALL be 1 exactly when the state is RUN (Moore output), and addr_a/addr_b SHALL be combinational from idx.
REQ-020 A handshake is valid&&ready in a cycle; on a handshake the block SHALL increment count by 1.
REQ-021 On a handshake with idx != limit_latched-1, the block SHALL increment idx by 1.
REQ-022 On a handshake with idx == limit_latched-1, the block SHALL enter DONE and hold idx.
REQ-023 While valid=1 and ready=0, idx, addr_a, addr_b and count SHALL hold their values.
REQ-024 DONE SHALL last exactly one cycle, with done=1 and valid=0, followed by IDLE.
REQ-025 A run SHALL produce exactly limit-base handshakes; idx SHALL never wrap, because idx<limit<=2^PAIR_W-1.
REQ-026 start asserted in RUN or DONE SHALL be ignored, and base/limit changes during a run SHALL have no effect.
REQ-027 abort=1 in RUN SHALL move the state to IDLE on the next edge with no done pulse, and count SHALL hold the pairs accepted so far.
REQ-028 abort and a handshake in the same cycle: the handshake SHALL count, then abort SHALL apply; abort takes priority over the DONE transition.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 In IDLE, addr_a/addr_b SHALL show the last idx; they are don't-care for consumers because valid=0.

Reset
REQ-031 While reset=0, the block SHALL be asynchronously forced to: state=IDLE, idx=0, count=0, valid=0, busy=0, done=0, err=0, addr_a=0, addr_b=1.
REQ-032 Reset asserted mid-run SHALL drop valid immediately with no done pulse, and the block SHALL start a new run only on a fresh start after release.
REQ-033 The first edge after reset release SHALL be able to accept start.

Verification
REQ-034 Directed test, full run: base=1024, limit=1536, start pulsed at cycle T, ready=1. Required: valid on T+1..T+512; first pair 2048/2049; last pair 3070/3071; done=1 only at T+513; count=512; IDLE at T+514.
REQ-035 Directed test, backpressure: base=0, limit=4, ready toggled 1,0,0,1,... Required: addresses hold while ready=0; exactly 4 handshakes with pairs 0/1, 2/3, 4/5, 6/7; a single done pulse.
REQ-036 Directed test, rejected start: base=1536, limit=1536, then base=1600, limit=1024. Required: one err pulse for each start; valid and busy stay 0.
REQ-037 Directed test, abort: base=1024, limit=1536, ready=1, abort asserted after 10 handshakes and in the same cycle as the 11th. Required: count=11; no done; IDLE next cycle.
REQ-038 Directed test, reset mid-run: reset=0 during RUN at idx=1100. Required: all outputs equal their REQ-031 values immediately; a new start with base=1024 restarts at 2048/2049.
REQ-039 Directed test, start ignored in RUN: second start with base=0, limit=2 while in RUN. Required: the run continues at the original range and count reaches the original limit-base.
